// File: rtl/mips_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : mips_pipeline
// Function : Five-stage in-order MIPS-subset core with unified 1024-word memory
//            and 32-entry register bank. Define MIPS_MUL_EN to implement MUL.
// Revision : 1.0 - initial release
// ============================================================================
module mips_pipeline (
    input  logic clk1,
    input  logic rst
);
    localparam logic [5:0]  c_OP_ADD   = 6'b000000;
    localparam logic [5:0]  c_OP_SUB   = 6'b000001;
    localparam logic [5:0]  c_OP_AND   = 6'b000010;
    localparam logic [5:0]  c_OP_OR    = 6'b000011;
    localparam logic [5:0]  c_OP_SLT   = 6'b000100;
    localparam logic [5:0]  c_OP_MUL   = 6'b000101;
    localparam logic [5:0]  c_OP_LW    = 6'b001000;
    localparam logic [5:0]  c_OP_SW    = 6'b001001;
    localparam logic [5:0]  c_OP_ADDI  = 6'b001010;
    localparam logic [5:0]  c_OP_SUBI  = 6'b001011;
    localparam logic [5:0]  c_OP_SLTI  = 6'b001100;
    localparam logic [5:0]  c_OP_BNEQZ = 6'b001101;
    localparam logic [5:0]  c_OP_BEQZ  = 6'b001110;
    localparam logic [5:0]  c_OP_HLT   = 6'b111111;
    localparam logic [31:0] c_NOP_IR   = 32'h4000_0000;

    typedef enum logic [2:0] {
        CL_NOP = 3'd0, CL_RR = 3'd1, CL_RI = 3'd2, CL_LW = 3'd3,
        CL_SW  = 3'd4, CL_BR = 3'd5, CL_HLT = 3'd6
    } iclass_t;

    logic [31:0] mem      [0:1023];
    logic [31:0] reg_bank [0:31];
    logic [31:0] PC;
    logic        HALTED;

    logic [31:0] r_ifid_ir, r_ifid_npc;
    iclass_t     r_ifid_cls;
    logic [31:0] r_idex_ir, r_idex_npc, r_idex_a, r_idex_b, r_idex_imm;
    iclass_t     r_idex_cls;
    logic [31:0] r_exmem_ir, r_exmem_alu, r_exmem_b;
    logic        r_exmem_cond;
    iclass_t     r_exmem_cls;
    logic [31:0] r_memwb_ir, r_memwb_alu, r_memwb_lmd;
    iclass_t     r_memwb_cls;

    logic [31:0] w_if_ir, w_id_a, w_id_b, w_ex_alu, w_wb_val;
    logic [5:0]  w_ex_op;
    logic [4:0]  w_id_rs, w_id_rt, w_wb_rd;
    logic        w_ex_cond, w_ex_taken, w_hlt_inflight, w_wb_en;
    logic        w_unused_ok;

    function automatic iclass_t f_decode(input logic [5:0] op);
        iclass_t cls;
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SLT: cls = CL_RR;
`ifdef MIPS_MUL_EN
            c_OP_MUL:                                        cls = CL_RR;
`endif
            c_OP_ADDI, c_OP_SUBI, c_OP_SLTI:                 cls = CL_RI;
            c_OP_LW:                                         cls = CL_LW;
            c_OP_SW:                                         cls = CL_SW;
            c_OP_BNEQZ, c_OP_BEQZ:                           cls = CL_BR;
            c_OP_HLT:                                        cls = CL_HLT;
            default:                                         cls = CL_NOP;
        endcase
        return cls;
    endfunction

    assign w_if_ir = mem[PC[9:0]];
    assign w_id_rs = r_ifid_ir[25:21];
    assign w_id_rt = r_ifid_ir[20:16];
    assign w_id_a  = (w_id_rs == 5'd0) ? 32'd0 : reg_bank[w_id_rs];
    assign w_id_b  = (w_id_rt == 5'd0) ? 32'd0 : reg_bank[w_id_rt];
    assign w_ex_op = r_idex_ir[31:26];

    // Once HLT is decoded, fetch stays parked until the core freezes.
    assign w_hlt_inflight = (r_ifid_cls == CL_HLT) || (r_idex_cls == CL_HLT) ||
                            (r_exmem_cls == CL_HLT) || (r_memwb_cls == CL_HLT);

    always_comb begin
        w_ex_alu  = '0;
        w_ex_cond = 1'b0;
        case (r_idex_cls)
            CL_RR: begin
                case (w_ex_op)
                    c_OP_ADD: w_ex_alu = r_idex_a + r_idex_b;
                    c_OP_SUB: w_ex_alu = r_idex_a - r_idex_b;
                    c_OP_AND: w_ex_alu = r_idex_a & r_idex_b;
                    c_OP_OR:  w_ex_alu = r_idex_a | r_idex_b;
                    c_OP_SLT: w_ex_alu = {31'd0, $signed(r_idex_a) < $signed(r_idex_b)};
`ifdef MIPS_MUL_EN
                    c_OP_MUL: w_ex_alu = r_idex_a * r_idex_b;
`endif
                    default:  w_ex_alu = '0;
                endcase
            end
            CL_RI: begin
                case (w_ex_op)
                    c_OP_ADDI: w_ex_alu = r_idex_a + r_idex_imm;
                    c_OP_SUBI: w_ex_alu = r_idex_a - r_idex_imm;
                    c_OP_SLTI: w_ex_alu = {31'd0, $signed(r_idex_a) < $signed(r_idex_imm)};
                    default:   w_ex_alu = '0;
                endcase
            end
            CL_LW, CL_SW: w_ex_alu = r_idex_a + r_idex_imm;
            CL_BR: begin
                w_ex_alu  = r_idex_npc + r_idex_imm;
                w_ex_cond = (w_ex_op == c_OP_BEQZ) ? (r_idex_a == 32'd0) : (r_idex_a != 32'd0);
            end
            default: ;
        endcase
    end

    assign w_ex_taken = (r_idex_cls == CL_BR) && w_ex_cond;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            r_ifid_ir    <= c_NOP_IR;
            r_ifid_npc   <= '0;
            r_ifid_cls   <= CL_NOP;
            r_idex_ir    <= c_NOP_IR;
            r_idex_npc   <= '0;
            r_idex_a     <= '0;
            r_idex_b     <= '0;
            r_idex_imm   <= '0;
            r_idex_cls   <= CL_NOP;
            r_exmem_ir   <= c_NOP_IR;
            r_exmem_alu  <= '0;
            r_exmem_b    <= '0;
            r_exmem_cond <= 1'b0;
            r_exmem_cls  <= CL_NOP;
            r_memwb_ir   <= c_NOP_IR;
            r_memwb_alu  <= '0;
            r_memwb_lmd  <= '0;
            r_memwb_cls  <= CL_NOP;
        end else if (!HALTED) begin
            // A taken branch overrides a parked fetch, squashing any HLT in ID.
            if (w_ex_taken) begin
                PC         <= w_ex_alu;
                r_ifid_ir  <= c_NOP_IR;
                r_ifid_cls <= CL_NOP;
            end else if (w_hlt_inflight) begin
                r_ifid_ir  <= c_NOP_IR;
                r_ifid_cls <= CL_NOP;
            end else begin
                r_ifid_ir  <= w_if_ir;
                r_ifid_cls <= f_decode(w_if_ir[31:26]);
                r_ifid_npc <= PC + 32'd1;
                PC         <= PC + 32'd1;
            end

            r_idex_npc <= r_ifid_npc;
            r_idex_a   <= w_id_a;
            r_idex_b   <= w_id_b;
            r_idex_imm <= {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};
            if (w_ex_taken) begin
                r_idex_ir  <= c_NOP_IR;
                r_idex_cls <= CL_NOP;
            end else begin
                r_idex_ir  <= r_ifid_ir;
                r_idex_cls <= r_ifid_cls;
            end

            r_exmem_ir   <= r_idex_ir;
            r_exmem_cls  <= r_idex_cls;
            r_exmem_alu  <= w_ex_alu;
            r_exmem_b    <= r_idex_b;
            r_exmem_cond <= w_ex_cond;

            r_memwb_ir   <= r_exmem_ir;
            r_memwb_cls  <= r_exmem_cls;
            r_memwb_alu  <= r_exmem_alu;
            r_memwb_lmd  <= mem[r_exmem_alu[9:0]];

            if (r_memwb_cls == CL_HLT) HALTED <= 1'b1;
        end
    end

    always_comb begin
        w_wb_rd  = r_memwb_ir[15:11];
        w_wb_val = r_memwb_alu;
        w_wb_en  = 1'b0;
        case (r_memwb_cls)
            CL_RR: w_wb_en = 1'b1;
            CL_RI: begin
                w_wb_rd = r_memwb_ir[20:16];
                w_wb_en = 1'b1;
            end
            CL_LW: begin
                w_wb_rd  = r_memwb_ir[20:16];
                w_wb_val = r_memwb_lmd;
                w_wb_en  = 1'b1;
            end
            default: ;
        endcase
        if (w_wb_rd == 5'd0) w_wb_en = 1'b0;
    end

    // Arrays carry no reset; reset empties the pipeline so no write is pending.
    always_ff @(posedge clk1) begin
        if (!HALTED) begin
            if (r_exmem_cls == CL_SW) mem[r_exmem_alu[9:0]] <= r_exmem_b;
            if (w_wb_en) reg_bank[w_wb_rd] <= w_wb_val;
        end
    end

    assign w_unused_ok = &{1'b0, r_exmem_cond, r_memwb_ir[31:21], r_memwb_ir[10:0]};

endmodule
`default_nettype wire

// File: tb/tb_mips_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_pipeline
// Function : Directed and random-program checks of mips_pipeline against an
//            instruction-level interpreter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_pipeline;
    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mul_en;

    logic [31:0] p_mem [0:1023];
    logic [31:0] p_reg [0:31];
    logic [31:0] m_mem [0:1023];
    logic [31:0] m_reg [0:31];

    localparam logic [31:0] c_NOP = 32'h4000_0000;
    localparam logic [31:0] c_HLT = 32'hFC00_0000;

    mips_pipeline dut (.clk1(clk1), .rst(rst));

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic load_begin();
        @(negedge clk1);
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) p_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) p_reg[i] = i;
    endtask

    task automatic load_commit();
        for (int i = 0; i < 1024; i++) dut.mem[i] = p_mem[i];
        for (int i = 0; i < 32; i++) dut.reg_bank[i] = p_reg[i];
        @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic run_halt(input int budget);
        int n = 0;
        while (!dut.HALTED && n < budget) begin
            @(posedge clk1);
            #1;
            n++;
        end
        chk("halt_reached", {31'd0, dut.HALTED}, 32'd1);
    endtask

    // Sequential instruction-set interpreter: one instruction per step.
    task automatic model_run();
        logic [31:0] pc, ir, a, b, imm, res;
        logic [5:0]  op;
        int          rs, rt, rd, dst;
        for (int i = 0; i < 1024; i++) m_mem[i] = p_mem[i];
        for (int i = 0; i < 32; i++) m_reg[i] = p_reg[i];
        pc = 0;
        for (int step = 0; step < 5000; step++) begin
            ir  = m_mem[pc % 1024];
            op  = ir[31:26];
            rs  = int'(ir[25:21]);
            rt  = int'(ir[20:16]);
            rd  = int'(ir[15:11]);
            a   = (rs == 0) ? 32'd0 : m_reg[rs];
            b   = (rt == 0) ? 32'd0 : m_reg[rt];
            imm = {{16{ir[15]}}, ir[15:0]};
            pc  = pc + 1;
            dst = 0;
            res = 0;
            if (op == 6'h3F) break;
            case (op)
                6'd0:  begin dst = rd; res = a + b; end
                6'd1:  begin dst = rd; res = a - b; end
                6'd2:  begin dst = rd; res = a & b; end
                6'd3:  begin dst = rd; res = a | b; end
                6'd4:  begin dst = rd; res = ($signed(a) < $signed(b)) ? 1 : 0; end
                6'd5:  if (mul_en) begin dst = rd; res = a * b; end
                6'd10: begin dst = rt; res = a + imm; end
                6'd11: begin dst = rt; res = a - imm; end
                6'd12: begin dst = rt; res = ($signed(a) < $signed(imm)) ? 1 : 0; end
                6'd8:  begin dst = rt; res = m_mem[(a + imm) % 1024]; end
                6'd9:  m_mem[(a + imm) % 1024] = b;
                6'd13: if (a != 0) pc = pc + imm;
                6'd14: if (a == 0) pc = pc + imm;
                default: ;
            endcase
            if (dst != 0) m_reg[dst] = res;
        end
    endtask

    task automatic gen_random(input int n);
        logic [5:0] rr_ops [6] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
        logic [5:0] ri_ops [3] = '{6'd10, 6'd11, 6'd12};
        int slot, maxv;
        load_begin();
        for (int i = 1; i < 31; i++) p_reg[i] = $urandom;
        p_reg[31] = 32'd600;
        for (int i = 600; i < 920; i++) p_mem[i] = $urandom;
        for (int i = 0; i < n; i++) begin
            slot = 4 * i;
            case ($urandom_range(0, 9))
                0, 1, 9: p_mem[slot] = enc_r(rr_ops[$urandom_range(0, 5)], $urandom_range(1, 30),
                                             $urandom_range(0, 31), $urandom_range(0, 31));
                2, 3:    p_mem[slot] = enc_i(ri_ops[$urandom_range(0, 2)], $urandom_range(1, 30),
                                             $urandom_range(0, 31), $urandom);
                4:       p_mem[slot] = $urandom_range(0, 1) ?
                             enc_i(6'd8, $urandom_range(1, 30), 31, $urandom_range(0, 300)) :
                             enc_i(6'd8, $urandom_range(1, 30), 0, $urandom_range(600, 900));
                5:       p_mem[slot] = $urandom_range(0, 1) ?
                             enc_i(6'd9, $urandom_range(0, 31), 31, $urandom_range(0, 300)) :
                             enc_i(6'd9, $urandom_range(0, 31), 0, $urandom_range(600, 900));
                6, 7: begin
                    maxv = (4 * n - slot - 1 < 12) ? 4 * n - slot - 1 : 12;
                    p_mem[slot] = enc_i($urandom_range(0, 1) ? 6'd13 : 6'd14, 0,
                                        $urandom_range(0, 31), $urandom_range(0, maxv));
                end
                default: p_mem[slot] = {6'b010001, 26'($urandom)};
            endcase
            for (int f = 1; f < 4; f++) p_mem[slot + f] = c_NOP;
        end
        p_mem[4 * n] = c_HLT;
    endtask

    task automatic load_store_prog();
        load_begin();
        p_mem[120] = 32'h11;
        p_mem[0] = 32'h2801_0078;
        for (int i = 1; i < 4; i++) p_mem[i] = 32'h0CE7_7800;
        p_mem[4] = 32'h2022_0000;
        for (int i = 5; i < 8; i++) p_mem[i] = 32'h0CE7_7800;
        p_mem[8]  = 32'h2422_0001;
        p_mem[9]  = c_HLT;
        p_mem[10] = 32'h2422_0002;
        load_commit();
    endtask

    initial begin
`ifdef MIPS_MUL_EN
        mul_en = 1'b1;
`else
        mul_en = 1'b0;
`endif
        #1;
        chk("reset_pc", dut.PC, 32'd0);
        chk("reset_halted", {31'd0, dut.HALTED}, 32'd0);

        // Load/store program with cycle-exact latency and freeze checks
        load_store_prog();
        @(posedge clk1); #1;
        chk("first_fetch_pc", dut.PC, 32'd1);
        repeat (3) @(posedge clk1);
        #1 chk("wb_not_yet", dut.reg_bank[1], 32'd1);
        @(posedge clk1); #1;
        chk("wb_edge5", dut.reg_bank[1], 32'd120);
        repeat (8) @(posedge clk1);
        #1 chk("halt_not_edge13", {31'd0, dut.HALTED}, 32'd0);
        @(posedge clk1); #1;
        chk("halt_edge14", {31'd0, dut.HALTED}, 32'd1);
        chk("ls_r1", dut.reg_bank[1], 32'd120);
        chk("ls_r2", dut.reg_bank[2], 32'd17);
        chk("ls_mem121", dut.mem[121], 32'd17);
        chk("ls_r15", dut.reg_bank[15], 32'd7);
        repeat (10) @(posedge clk1);
        #1 chk("frz_pc", dut.PC, 32'd10);
        chk("frz_mem122", dut.mem[122], 32'd0);
        chk("frz_r2", dut.reg_bank[2], 32'd17);
        chk("frz_halted", {31'd0, dut.HALTED}, 32'd1);

        // Reset mid-run
        load_store_prog();
        repeat (6) @(posedge clk1);
        #2 rst = 1'b1;
        #1 chk("rst_pc", dut.PC, 32'd0);
        chk("rst_halted", {31'd0, dut.HALTED}, 32'd0);
        repeat (3) @(posedge clk1);
        #1 chk("rst_no_lw_wb", dut.reg_bank[2], 32'd2);
        chk("rst_mem120", dut.mem[120], 32'h11);
        chk("rst_pc_held", dut.PC, 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        run_halt(100);
        chk("rerun_r1", dut.reg_bank[1], 32'd120);
        chk("rerun_r2", dut.reg_bank[2], 32'd17);
        chk("rerun_mem121", dut.mem[121], 32'd17);

        // ALU
        load_begin();
        p_mem[0] = enc_i(6'd10, 1, 0, 10);
        p_mem[1] = enc_i(6'd10, 2, 0, 20);
        p_mem[2] = enc_i(6'd10, 3, 0, -5);
        p_mem[3] = c_NOP;
        p_mem[4] = c_NOP;
        p_mem[5] = enc_r(6'd0, 4, 1, 2);
        p_mem[6] = enc_r(6'd1, 5, 1, 2);
        p_mem[7] = enc_r(6'd4, 6, 3, 1);
        p_mem[8] = enc_r(6'd2, 7, 1, 2);
        p_mem[9] = c_HLT;
        load_commit();
        run_halt(100);
        chk("alu_add", dut.reg_bank[4], 32'd30);
        chk("alu_sub", dut.reg_bank[5], 32'hFFFF_FFF6);
        chk("alu_slt", dut.reg_bank[6], 32'd1);
        chk("alu_and", dut.reg_bank[7], 32'd0);

        // Branch taken (R1 = 0) and not taken (R1 = 5)
        for (int t = 0; t < 2; t++) begin
            load_begin();
            p_mem[0] = enc_i(6'd10, 1, 0, (t == 0) ? 0 : 5);
            for (int i = 1; i < 4; i++) p_mem[i] = c_NOP;
            p_mem[4] = enc_i(6'd14, 0, 1, 1);
            p_mem[5] = enc_i(6'd10, 2, 0, 99);
            p_mem[6] = enc_i(6'd10, 3, 0, 7);
            p_mem[7] = c_HLT;
            load_commit();
            run_halt(100);
            chk("br_r2", dut.reg_bank[2], (t == 0) ? 32'd2 : 32'd99);
            chk("br_r3", dut.reg_bank[3], 32'd7);
        end

        // Multiply
        load_begin();
        p_reg[1] = 32'd6;
        p_reg[2] = 32'd7;
        p_mem[0] = enc_r(6'd5, 3, 1, 2);
        p_mem[1] = c_HLT;
        load_commit();
        run_halt(100);
        chk("mul_r3", dut.reg_bank[3], mul_en ? 32'd42 : 32'd3);

        // Random programs against the interpreter
        for (int p = 0; p < 8; p++) begin
            gen_random(16);
            model_run();
            load_commit();
            run_halt(400);
            for (int i = 0; i < 32; i++) chk($sformatf("rnd%0d_r%0d", p, i), dut.reg_bank[i], m_reg[i]);
            for (int i = 0; i < 1024; i++) chk($sformatf("rnd%0d_m%0d", p, i), dut.mem[i], m_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
